// File: rtl/tisc_sequencer.sv
// -----------------------------------------------------------------------------
// tisc_sequencer
//
// Fetch/decode/execute sequencer for a tiny 16-bit instruction set. It fetches
// one instruction word at a time from a shared single-port memory, decodes the
// low nibble as the opcode and runs a memory phase for LOAD/STORE. A LOAD then
// spends one write-back cycle strobing the register file.
//
// Instruction word layout:
//   ir[3:0]        opcode: 0000 LOAD, 0001 STORE, 1111 HALT, anything else NOP
//   ir[7:4]        destination register (LOAD)
//   ir[PC_W+7:8]   data address (LOAD/STORE); this requires PC_W <= 8
//
// Parameters:
//   PC_W      program counter / memory address width
//   RESET_PC  pc value loaded on reset
//
// Ports:
//   clk           single clock, rising-edge
//   rst           synchronous active-high reset
//   mem_req       memory request, held until mem_ready
//   mem_we        request is a write (valid only while mem_req=1)
//   mem_addr      request address
//   mem_rdata     read data, valid in the mem_ready cycle
//   mem_ready     access accepted/completed this cycle (ignored when idle)
//   ir            instruction register
//   pc            address of the next instruction to fetch
//   reg_write_en  one-cycle register-file write strobe (LOAD only)
//   wb_data       load data for the register file
//   wb_addr       destination register, ir[7:4]
//   halted        sequencer is parked in HALT until reset
// -----------------------------------------------------------------------------
module tisc_sequencer #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ready,
    output logic [15:0]     ir,
    output logic [PC_W-1:0] pc,
    output logic            reg_write_en,
    output logic [15:0]     wb_data,
    output logic [3:0]      wb_addr,
    output logic            halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     wb_data_q, wb_data_d;

    logic [3:0]      opcode;
    logic            is_load;
    logic            is_store;
    logic            is_halt;
    logic [PC_W-1:0] data_addr;

    assign opcode    = ir_q[3:0];
    assign is_load   = (opcode == 4'b0000);
    assign is_store  = (opcode == 4'b0001);
    assign is_halt   = (opcode == 4'b1111);
    assign data_addr = ir_q[PC_W+7:8];

    // Request outputs depend only on the state and the latched instruction,
    // so they cannot change while a request waits for mem_ready.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        wb_data_d    = wb_data_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = pc_q;
        reg_write_en = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else if (is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_store;
                mem_addr = data_addr;
                if (mem_ready) begin
                    if (is_store) begin
                        state_d = ST_FETCH;
                    end else begin
                        wb_data_d = mem_rdata;
                        state_d   = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // While reset is held the memory must see no request and the
        // register file no write, whatever state we are leaving.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            reg_write_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC_V;
            ir_q      <= 16'h0000;
            wb_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign ir      = ir_q;
    assign pc      = pc_q;
    assign wb_data = wb_data_q;
    assign wb_addr = ir_q[7:4];

endmodule

// File: tb/tb_tisc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tisc_sequencer
//
// Self-checking bench for tisc_sequencer. A behavioural instruction-level model
// walks the program in the bench's memory image, predicting each memory access
// (address, direction), the instruction/pc visible after a fetch, register
// write-backs, per-instruction latency with zero-wait memory and the halt
// behaviour. Directed programs cover the documented scenarios; randomized
// programs with random wait states and stray mem_ready pulses follow.
// -----------------------------------------------------------------------------
module tb_tisc_sequencer;

    localparam int PC_W     = 8;
    localparam int RESET_PC = 0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_req;
    logic            mem_we;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_rdata = 16'h0000;
    logic            mem_ready = 1'b0;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc;
    logic            reg_write_en;
    logic [15:0]     wb_data;
    logic [3:0]      wb_addr;
    logic            halted;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    tisc_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .ir           (ir),
        .pc           (pc),
        .reg_write_en (reg_write_en),
        .wb_data      (wb_data),
        .wb_addr      (wb_addr),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive memory inputs for the coming edge, then land just after the next
    // falling edge where outputs are sampled.
    task automatic cycle(input logic rdy, input logic [15:0] rd);
        mem_ready = rdy;
        mem_rdata = rd;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] word);
        for (int i = 0; i < 256; i++) mem[i] = word;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc", {24'd0, pc}, RESET_PC);
        chk("rst_ir", {16'd0, ir}, 32'd0);
        chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_rwe", {31'd0, reg_write_en}, 32'd0);
        rst = 1'b0;
        #1;
    endtask

    // One memory access: the request must be present and unchanged for every
    // wait cycle and the ready cycle.
    task automatic expect_access(input logic [PC_W-1:0] addr, input logic we, input int stall);
        for (int w = 0; w <= stall; w++) begin
            chk("acc_req", {31'd0, mem_req}, 32'd1);
            chk("acc_we", {31'd0, mem_we}, {31'd0, we});
            chk("acc_addr", {24'd0, mem_addr}, {24'd0, addr});
            chk("acc_rwe", {31'd0, reg_write_en}, 32'd0);
            if (w == stall) cycle(1'b1, mem[addr]);
            else            cycle(1'b0, 16'($urandom));
        end
    endtask

    // A cycle with no request; a random mem_ready is offered and must be ignored.
    task automatic idle(input logic exp_rwe);
        chk("idle_req", {31'd0, mem_req}, 32'd0);
        chk("idle_we", {31'd0, mem_we}, 32'd0);
        chk("rwe", {31'd0, reg_write_en}, {31'd0, exp_rwe});
        cycle(1'($urandom_range(0, 1)), 16'($urandom));
    endtask

    // mode 0: zero-wait; 1: random waits; 2: zero-wait fetch, 3 waits on data
    task automatic run_program(input int max_instr, input int mode);
        logic [PC_W-1:0] m_pc;
        logic [PC_W-1:0] fa;
        logic [PC_W-1:0] da;
        logic [15:0]     instr;
        logic [3:0]      op;
        int              start, lat, exp_lat, fs, ds;
        m_pc = PC_W'(RESET_PC);
        for (int i = 0; i < max_instr; i++) begin
            start = cyc;
            fa    = m_pc;
            instr = mem[fa];
            op    = instr[3:0];
            da    = instr[PC_W+7:8];
            fs    = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            ds    = (mode == 1) ? int'($urandom_range(0, 3)) : ((mode == 2) ? 3 : 0);

            expect_access(fa, 1'b0, fs);
            m_pc = m_pc + 1'b1;
            chk("dec_ir", {16'd0, ir}, {16'd0, instr});
            chk("dec_pc", {24'd0, pc}, {24'd0, m_pc});
            chk("dec_halted", {31'd0, halted}, 32'd0);
            if (fa == 8'hFF) chk("pc_wrap", {24'd0, pc}, 32'd0);
            idle(1'b0);

            if (op == 4'h0 || op == 4'h1) begin
                expect_access(da, op == 4'h1, ds);
                if (op == 4'h0) begin
                    chk("wb_addr", {28'd0, wb_addr}, {28'd0, instr[7:4]});
                    chk("wb_data", {16'd0, wb_data}, {16'd0, mem[da]});
                    idle(1'b1);
                end
            end

            lat     = cyc - start;
            exp_lat = (op == 4'h0) ? 4 : ((op == 4'h1) ? 3 : 2);
            if (mode == 0) chk("latency", lat, exp_lat);
            $display("TXN pc=%02h ir=%04h op=%0h cycles=%0d", fa, instr, op, lat);

            if (op == 4'hF) begin
                for (int k = 0; k < 20; k++) begin
                    chk("halt_halted", {31'd0, halted}, 32'd1);
                    chk("halt_pc", {24'd0, pc}, {24'd0, m_pc});
                    idle(1'b0);
                end
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        int         r;
        @(negedge clk);

        // LOAD r1,0x2A with zero-wait memory
        fill(16'h0005);
        mem[0]     = 16'h2A10;
        mem[8'h2A] = 16'hBEEF;
        do_reset();
        run_program(1, 0);
        chk("load_pc", {24'd0, pc}, 32'd1);
        chk("load_wb_data", {16'd0, wb_data}, 32'h0000BEEF);

        // STORE 0x10 with 3 wait cycles in the data phase
        fill(16'h0005);
        mem[0] = 16'h1031;
        do_reset();
        run_program(2, 2);

        // NOP, NOP, HALT
        fill(16'h0005);
        mem[0] = 16'h0005;
        mem[1] = 16'h0007;
        mem[2] = 16'h000F;
        do_reset();
        run_program(3, 0);
        chk("halt_final_pc", {24'd0, pc}, 32'd3);

        // pc wrap across 0xFF
        fill(16'h0005);
        do_reset();
        run_program(257, 0);
        chk("wrap_final_pc", {24'd0, pc}, 32'd1);

        // reset coincident with mem_ready in a LOAD data phase
        fill(16'h0005);
        mem[0]     = 16'h4030;
        mem[8'h40] = 16'h1234;
        do_reset();
        expect_access(8'h00, 1'b0, 0);
        idle(1'b0);
        chk("rmem_req", {31'd0, mem_req}, 32'd1);
        chk("rmem_addr", {24'd0, mem_addr}, 32'h40);
        rst = 1'b1;
        #1;
        chk("rmem_req_rst", {31'd0, mem_req}, 32'd0);
        cycle(1'b1, mem[8'h40]);
        chk("rmem_after_req", {31'd0, mem_req}, 32'd0);
        chk("rmem_after_rwe", {31'd0, reg_write_en}, 32'd0);
        chk("rmem_after_wb", {16'd0, wb_data}, 32'd0);
        chk("rmem_after_ir", {16'd0, ir}, 32'd0);
        chk("rmem_after_pc", {24'd0, pc}, RESET_PC);
        cycle(1'b1, 16'($urandom));
        rst = 1'b0;
        #1;
        chk("rmem_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("rmem_fetch_we", {31'd0, mem_we}, 32'd0);
        chk("rmem_fetch_addr", {24'd0, mem_addr}, RESET_PC);
        chk("rmem_fetch_rwe", {31'd0, reg_write_en}, 32'd0);

        // randomized programs
        for (int run = 0; run < 8; run++) begin
            for (int i = 0; i < 256; i++) begin
                r = int'($urandom_range(0, 19));
                if (r <= 6)       op = 4'h0;
                else if (r <= 12) op = 4'h1;
                else if (r == 13) op = 4'hF;
                else              op = 4'(2 + $urandom_range(0, 12));
                mem[i] = {8'($urandom), 4'($urandom), op};
            end
            do_reset();
            run_program(40, run % 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tisc_sequencer.md
TISC_SEQUENCER -- requirements
Module: tisc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter and memory address width.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_req  output  1  memory access request, held until accepted.
REQ-006 SHALL have port mem_we  output  1  access is a write (valid while mem_req=1).
REQ-007 SHALL have port mem_addr  output  PC_W  access address.
REQ-008 SHALL have port mem_rdata  input  16  read data, valid in the cycle mem_ready=1.
REQ-009 SHALL have port mem_ready  input  1  access accepted/completed this cycle.
REQ-010 SHALL have port ir  output  16  instruction register.
REQ-011 SHALL have port pc  output  PC_W  address of the next instruction to fetch.
REQ-012 SHALL have port reg_write_en  output  1  register-file write strobe, one cycle.
REQ-013 SHALL have port wb_data  output  16  load data for the register file.
REQ-014 SHALL have port wb_addr  output  4  destination register, equal to ir[7:4].
REQ-015 SHALL have port halted  output  1  sequencer is in HALT.

Function
REQ-016 SHALL decode opcode = ir[3:0]: 0000 LOAD, 0001 STORE, 1111 HALT, all others NOP.
REQ-017 SHALL use data address = ir[PC_W+7:8] for LOAD/STORE.
REQ-018 SHALL implement states FETCH, DECODE, MEM, WB and HALT.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready=1: ir<=mem_rdata, pc<=pc+1 (mod 2^PC_W), next DECODE. Otherwise stay in FETCH.
REQ-020 DECODE: no request. LOAD/STORE -> MEM; HALT -> HALT; NOP -> FETCH.
REQ-021 MEM: mem_req=1, mem_addr=data address, mem_we=1 iff STORE. On mem_ready=1: LOAD latches wb_data<=mem_rdata and goes to WB; STORE goes to FETCH. Otherwise stay in MEM.
REQ-022 WB: reg_write_en=1 for exactly this cycle, next FETCH.
REQ-023 HALT: halted=1, mem_req=0, reg_write_en=0; leaves only on rst.
REQ-024 mem_req, mem_we and mem_addr SHALL stay stable from assertion until the mem_ready cycle inclusive.
REQ-025 mem_req SHALL be 0 in DECODE, WB and HALT; mem_we SHALL be 0 whenever mem_req=0.
REQ-026 mem_ready while mem_req=0 SHALL be ignored.
REQ-027 With zero-wait memory, latency SHALL be NOP 2, STORE 3, LOAD 4 cycles per instruction.
REQ-028 pc SHALL wrap from 2^PC_W-1 to 0 with no other effect.
REQ-029 reg_write_en SHALL never assert for STORE, NOP or HALT.

Reset
REQ-030 rst=1 at a clock edge SHALL force state FETCH, pc=RESET_PC, ir=0, wb_data=0, reg_write_en=0, halted=0.
REQ-031 While rst=1, mem_req SHALL be 0 and mem_we SHALL be 0.
REQ-032 rst SHALL take priority over every transition, including a same-cycle mem_ready or a pending WB; an interrupted access SHALL be abandoned with no ir, pc or register write.
REQ-033 The first fetch after rst deassertion SHALL request address RESET_PC.

Verification
REQ-034 Zero-wait memory, mem[0]=16'h2A10 (LOAD r1,0x2A), mem[0x2A]=16'hBEEF -> reads at 0x00 then 0x2A, reg_write_en pulse on cycle 4 with wb_addr=1, wb_data=16'hBEEF, pc=1.
REQ-035 mem[0]=16'h1031 (STORE 0x10), mem_ready delayed 3 cycles in MEM -> mem_we=1 and mem_addr=0x10 held stable for 4 cycles, no reg_write_en, next fetch from pc=1.
REQ-036 mem[0..2]=16'h0005,16'h0007,16'h000F -> two NOPs of 2 cycles each, then halted=1 after the third DECODE, pc=3, no further mem_req over 20 cycles.
REQ-037 pc=8'hFF fetching a NOP -> pc becomes 8'h00 and the next fetch is at 0x00.
REQ-038 rst asserted in the same cycle as mem_ready during a LOAD MEM -> no reg_write_en, wb_data=0; the next cycle shows mem_req=0, and the cycle after shows a fetch at RESET_PC.
